// File: rtl/johnson_code_monitor.sv
// johnson_code_monitor
//   Receive-side decoder and protocol checker for a Johnson-coded state bus.
//   Decodes each sampled code to a binary count and a one-hot vector, flags
//   codes that are not Johnson codes, and flags out-of-order steps while
//   locked. A lock FSM (IDLE/ACQUIRE/LOCKED) tracks sequence health. A
//   saturating counter accumulates error events.
//
// Parameters
//   WIDTH     : Johnson stages; the sequence length is N = 2*WIDTH.
//   LOCK_CNT  : consecutive legal +1 steps needed to enter LOCKED (1..15).
//   ERR_CNT_W : width of err_count.
//
// Ports
//   clk          in   clock; all state updates on its rising edge
//   rstn         in   synchronous active-low reset
//   in_valid     in   code_in is sampled this cycle
//   code_in      in   Johnson code; the MSB is stage A
//   clr_err      in   synchronous clear of err_count (beats an increment)
//   out_valid    out  count_out/one_hot were updated from a legal sample
//   count_out    out  decoded count, held across illegal samples
//   one_hot      out  one_hot[count_out] = 1
//   locked       out  the FSM is in LOCKED
//   illegal_code out  one-cycle pulse per non-Johnson sample
//   seq_error    out  one-cycle pulse per out-of-order legal sample while LOCKED
//   err_count    out  saturating count of illegal_code and seq_error pulses
module johnson_code_monitor #(
  parameter int WIDTH     = 4,
  parameter int LOCK_CNT  = 2,
  parameter int ERR_CNT_W = 8
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          in_valid,
  input  logic [WIDTH-1:0]              code_in,
  input  logic                          clr_err,
  output logic                          out_valid,
  output logic [$clog2(2*WIDTH)-1:0]    count_out,
  output logic [2*WIDTH-1:0]            one_hot,
  output logic                          locked,
  output logic                          illegal_code,
  output logic                          seq_error,
  output logic [ERR_CNT_W-1:0]          err_count
);

  localparam int N  = 2 * WIDTH;
  localparam int CW = $clog2(N);

  localparam logic [WIDTH-1:0] ALL1   = '1;
  localparam logic [3:0]       LOCK_N = 4'(LOCK_CNT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACQUIRE,
    S_LOCKED
  } state_t;

  state_t               state_q, state_n;
  logic [CW-1:0]        prev_q, prev_n;
  logic [3:0]           good_q, good_n;

  logic                 out_valid_n;
  logic [CW-1:0]        count_n;
  logic [N-1:0]         one_hot_n;
  logic                 locked_n;
  logic                 illegal_n;
  logic                 seq_err_n;
  logic [ERR_CNT_W-1:0] err_n;

  // Decoder: 1^k 0^(W-k) -> k (k = 0..W), 0^k 1^(W-k) -> W+k (k = 1..W-1).
  logic                 dec_legal;
  logic [CW-1:0]        dec_cnt;

  always_comb begin
    dec_legal = 1'b0;
    dec_cnt   = '0;
    for (int unsigned k = 0; k <= WIDTH; k++) begin
      if (code_in == ~(ALL1 >> k)) begin
        dec_legal = 1'b1;
        dec_cnt   = CW'(k);
      end
    end
    for (int unsigned k = 1; k < WIDTH; k++) begin
      if (code_in == (ALL1 >> k)) begin
        dec_legal = 1'b1;
        dec_cnt   = CW'(WIDTH + k);
      end
    end
  end

  // Step classification against the last accepted count.
  logic [CW-1:0] prev_inc;
  logic          is_succ;
  logic          is_hold;
  logic [3:0]    good_inc;

  always_comb begin
    prev_inc = (prev_q == CW'(N - 1)) ? '0 : prev_q + CW'(1);
    is_succ  = (dec_cnt == prev_inc);
    is_hold  = (dec_cnt == prev_q);
    good_inc = good_q + 4'd1;
  end

  // Next state, next outputs.
  always_comb begin
    state_n     = state_q;
    prev_n      = prev_q;
    good_n      = good_q;
    out_valid_n = 1'b0;
    count_n     = count_out;
    one_hot_n   = one_hot;
    illegal_n   = 1'b0;
    seq_err_n   = 1'b0;

    if (in_valid) begin
      if (dec_legal) begin
        out_valid_n        = 1'b1;
        count_n            = dec_cnt;
        one_hot_n          = '0;
        one_hot_n[dec_cnt] = 1'b1;
      end else begin
        illegal_n = 1'b1;
      end

      unique case (state_q)
        S_IDLE: begin
          if (dec_legal) begin
            state_n = S_ACQUIRE;
            prev_n  = dec_cnt;
            good_n  = '0;
          end
        end
        S_ACQUIRE: begin
          if (!dec_legal) begin
            state_n = S_IDLE;
          end else if (is_hold) begin
            state_n = S_ACQUIRE;
          end else if (is_succ) begin
            prev_n = dec_cnt;
            good_n = good_inc;
            if (good_inc >= LOCK_N) state_n = S_LOCKED;
          end else begin
            prev_n = dec_cnt;
            good_n = '0;
          end
        end
        S_LOCKED: begin
          if (!dec_legal) begin
            state_n = S_IDLE;
          end else if (is_succ) begin
            prev_n = dec_cnt;
          end else if (!is_hold) begin
            seq_err_n = 1'b1;
            state_n   = S_ACQUIRE;
            prev_n    = dec_cnt;
            good_n    = '0;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end

    locked_n = (state_n == S_LOCKED);

    // illegal_n and seq_err_n are mutually exclusive, so one increment covers both.
    err_n = err_count;
    if (clr_err) begin
      err_n = '0;
    end else if ((illegal_n || seq_err_n) && (err_count != '1)) begin
      err_n = err_count + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      prev_q       <= '0;
      good_q       <= '0;
      out_valid    <= 1'b0;
      count_out    <= '0;
      one_hot      <= '0;
      locked       <= 1'b0;
      illegal_code <= 1'b0;
      seq_error    <= 1'b0;
      err_count    <= '0;
    end else begin
      state_q      <= state_n;
      prev_q       <= prev_n;
      good_q       <= good_n;
      out_valid    <= out_valid_n;
      count_out    <= count_n;
      one_hot      <= one_hot_n;
      locked       <= locked_n;
      illegal_code <= illegal_n;
      seq_error    <= seq_err_n;
      err_count    <= err_n;
    end
  end

endmodule

// File: tb/tb_johnson_code_monitor.sv
module tb_johnson_code_monitor;

  logic       clk;
  logic       rstn;
  logic       in_valid;
  logic [3:0] code_in;
  logic       clr_err;

  logic       out_valid;
  logic [2:0] count_out;
  logic [7:0] one_hot;
  logic       locked;
  logic       illegal_code;
  logic       seq_error;
  logic [7:0] err_count;

  logic       s_out_valid;
  logic [2:0] s_count_out;
  logic [7:0] s_one_hot;
  logic       s_locked;
  logic       s_illegal_code;
  logic       s_seq_error;
  logic [1:0] s_err_count;

  int checks = 0;
  int errors = 0;

  johnson_code_monitor #(.WIDTH(4), .LOCK_CNT(2), .ERR_CNT_W(8)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .code_in(code_in), .clr_err(clr_err),
    .out_valid(out_valid), .count_out(count_out), .one_hot(one_hot), .locked(locked),
    .illegal_code(illegal_code), .seq_error(seq_error), .err_count(err_count)
  );

  johnson_code_monitor #(.WIDTH(4), .LOCK_CNT(2), .ERR_CNT_W(2)) dut_sat (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .code_in(code_in), .clr_err(clr_err),
    .out_valid(s_out_valid), .count_out(s_count_out), .one_hot(s_one_hot), .locked(s_locked),
    .illegal_code(s_illegal_code), .seq_error(s_seq_error), .err_count(s_err_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] code);
    in_valid = 1'b1;
    code_in  = code;
    tick();
  endtask

  task automatic test_reset();
    rstn = 1'b0; in_valid = 1'b1; code_in = 4'b1000; clr_err = 1'b0;
    tick(); tick();
    checks++; if (count_out !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count_out); end
    checks++; if (one_hot !== 8'h00) begin errors++; $display("FAIL reset_onehot got %h exp 00", one_hot); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b exp 0", locked); end
    checks++; if (illegal_code !== 1'b0 || seq_error !== 1'b0) begin errors++; $display("FAIL reset_pulses got %b%b exp 00", illegal_code, seq_error); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err got %0d exp 0", err_count); end
  endtask

  task automatic test_lock_in();
    logic [3:0] codes [3] = '{4'b0000, 4'b1000, 4'b1100};
    logic [7:0] oh    [3] = '{8'h01, 8'h02, 8'h04};
    logic       lk    [3] = '{1'b0, 1'b0, 1'b1};
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(codes[i]);
      checks++; if (count_out !== 3'(i)) begin errors++; $display("FAIL lock_count[%0d] got %0d exp %0d", i, count_out, i); end
      checks++; if (one_hot !== oh[i]) begin errors++; $display("FAIL lock_onehot[%0d] got %h exp %h", i, one_hot, oh[i]); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lock_valid[%0d] got %b exp 1", i, out_valid); end
      checks++; if (locked !== lk[i]) begin errors++; $display("FAIL lock_locked[%0d] got %b exp %b", i, locked, lk[i]); end
    end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL lock_err got %0d exp 0", err_count); end
  endtask

  task automatic test_wrap();
    logic [3:0] codes [7] = '{4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000, 4'b1000};
    logic [2:0] exp   [7] = '{3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
    for (int i = 0; i < 7; i++) begin
      drive(codes[i]);
      checks++; if (count_out !== exp[i]) begin errors++; $display("FAIL wrap_count[%0d] got %0d exp %0d", i, count_out, exp[i]); end
      checks++; if (seq_error !== 1'b0 || locked !== 1'b1) begin errors++; $display("FAIL wrap_state[%0d] got seq=%b lock=%b exp seq=0 lock=1", i, seq_error, locked); end
    end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL wrap_err got %0d exp 0", err_count); end
    drive(4'b1100);
    checks++; if (count_out !== 3'd2 || locked !== 1'b1) begin errors++; $display("FAIL wrap_to2 got cnt=%0d lock=%b exp cnt=2 lock=1", count_out, locked); end
  endtask

  task automatic test_illegal();
    drive(4'b1010);
    checks++; if (illegal_code !== 1'b1) begin errors++; $display("FAIL ill_pulse got %b exp 1", illegal_code); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ill_valid got %b exp 0", out_valid); end
    checks++; if (count_out !== 3'd2 || one_hot !== 8'h04) begin errors++; $display("FAIL ill_hold got cnt=%0d oh=%h exp cnt=2 oh=04", count_out, one_hot); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL ill_locked got %b exp 0", locked); end
    checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL ill_err got %0d exp 1", err_count); end
    drive(4'b1110);
    checks++; if (illegal_code !== 1'b0 || count_out !== 3'd3 || out_valid !== 1'b1) begin errors++; $display("FAIL ill_recover got ill=%b cnt=%0d v=%b exp ill=0 cnt=3 v=1", illegal_code, count_out, out_valid); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL ill_acq_locked got %b exp 0", locked); end
    drive(4'b1111);
    drive(4'b0111);
    checks++; if (locked !== 1'b1 || count_out !== 3'd5) begin errors++; $display("FAIL ill_relock got lock=%b cnt=%0d exp lock=1 cnt=5", locked, count_out); end
  endtask

  task automatic test_seq_error();
    drive(4'b0000);
    checks++; if (seq_error !== 1'b1) begin errors++; $display("FAIL seq_pulse got %b exp 1", seq_error); end
    checks++; if (err_count !== 8'd2) begin errors++; $display("FAIL seq_err got %0d exp 2", err_count); end
    checks++; if (locked !== 1'b0 || count_out !== 3'd0 || illegal_code !== 1'b0) begin errors++; $display("FAIL seq_state got lock=%b cnt=%0d ill=%b exp lock=0 cnt=0 ill=0", locked, count_out, illegal_code); end
    drive(4'b1000);
    checks++; if (seq_error !== 1'b0 || locked !== 1'b0) begin errors++; $display("FAIL seq_step1 got seq=%b lock=%b exp seq=0 lock=0", seq_error, locked); end
    drive(4'b1100);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL seq_relock got %b exp 1", locked); end
    for (int i = 0; i < 3; i++) begin
      drive(4'b1100);
      checks++; if (seq_error !== 1'b0 || illegal_code !== 1'b0 || locked !== 1'b1 || count_out !== 3'd2) begin errors++; $display("FAIL hold[%0d] got seq=%b ill=%b lock=%b cnt=%0d exp 0 0 1 2", i, seq_error, illegal_code, locked, count_out); end
    end
    in_valid = 1'b0; code_in = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out_valid !== 1'b0 || illegal_code !== 1'b0 || locked !== 1'b1 || count_out !== 3'd2 || err_count !== 8'd2) begin errors++; $display("FAIL gap[%0d] got v=%b ill=%b lock=%b cnt=%0d err=%0d exp 0 0 1 2 2", i, out_valid, illegal_code, locked, count_out, err_count); end
    end
  endtask

  task automatic test_back_to_back();
    drive(4'b1010);
    checks++; if (illegal_code !== 1'b1 || err_count !== 8'd3) begin errors++; $display("FAIL b2b_first got ill=%b err=%0d exp ill=1 err=3", illegal_code, err_count); end
    drive(4'b0101);
    checks++; if (illegal_code !== 1'b1 || err_count !== 8'd4) begin errors++; $display("FAIL b2b_second got ill=%b err=%0d exp ill=1 err=4", illegal_code, err_count); end
    in_valid = 1'b0; clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checks++; if (illegal_code !== 1'b0 || err_count !== 8'd0) begin errors++; $display("FAIL b2b_clear got ill=%b err=%0d exp ill=0 err=0", illegal_code, err_count); end
  endtask

  task automatic test_err_saturate();
    logic [1:0] exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    rstn = 1'b0; in_valid = 1'b0;
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(4'b1001);
      checks++; if (s_err_count !== exp[i]) begin errors++; $display("FAIL sat_err[%0d] got %0d exp %0d", i, s_err_count, exp[i]); end
    end
    clr_err = 1'b1;
    drive(4'b1001);
    clr_err = 1'b0;
    checks++; if (s_illegal_code !== 1'b1 || s_err_count !== 2'd0) begin errors++; $display("FAIL sat_clr got ill=%b err=%0d exp ill=1 err=0", s_illegal_code, s_err_count); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL sat_clr_wide got %0d exp 0", err_count); end
  endtask

  task automatic test_reset_mid();
    logic [3:0] codes [3] = '{4'b0011, 4'b0001, 4'b0000};
    logic [2:0] exp   [3] = '{3'd6, 3'd7, 3'd0};
    logic       lk    [3] = '{1'b0, 1'b0, 1'b1};
    drive(4'b1100);
    drive(4'b1110);
    drive(4'b1111);
    checks++; if (locked !== 1'b1 || count_out !== 3'd4) begin errors++; $display("FAIL mid_prelock got lock=%b cnt=%0d exp lock=1 cnt=4", locked, count_out); end
    rstn = 1'b0; in_valid = 1'b1; code_in = 4'b0111; clr_err = 1'b0;
    tick();
    rstn = 1'b1;
    checks++; if (count_out !== 3'd0 || one_hot !== 8'h00 || out_valid !== 1'b0 || locked !== 1'b0 || err_count !== 8'd0) begin errors++; $display("FAIL mid_reset got cnt=%0d oh=%h v=%b lock=%b err=%0d exp all 0", count_out, one_hot, out_valid, locked, err_count); end
    for (int i = 0; i < 3; i++) begin
      drive(codes[i]);
      checks++; if (count_out !== exp[i] || locked !== lk[i]) begin errors++; $display("FAIL mid_reacq[%0d] got cnt=%0d lock=%b exp cnt=%0d lock=%b", i, count_out, locked, exp[i], lk[i]); end
    end
  endtask

  initial begin
    rstn = 1'b0; in_valid = 1'b0; code_in = 4'b0000; clr_err = 1'b0;
    test_reset();
    test_lock_in();
    test_wrap();
    test_illegal();
    test_seq_error();
    test_back_to_back();
    test_err_saturate();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/johnson_code_monitor.md
# johnson_code_monitor

Receive-side companion to the team's Johnson counters. Samples a WIDTH-bit Johnson code bus, such as a 4-bit A,B,C,E ring driven from another block, and decodes it to a binary count and a one-hot vector. It checks every code for legality and every step for sequence order, runs a lock state machine, and keeps a saturating error counter. It sits at the consuming end of any Johnson-coded state bus, as a decoder and protocol checker.

## Interface
- WIDTH, 4, Johnson stages; the sequence length is N = 2*WIDTH.
- LOCK_CNT, 2, consecutive legal +1 steps needed to enter LOCKED (1..15).
- ERR_CNT_W, 8, width of the error counter.

Ports:
- clk  in  1  single clock; all state updates on posedge clk.
- rstn  in  1  reset, synchronous, active-low.
- in_valid  in  1  code_in is sampled this cycle.
- code_in  in  WIDTH  Johnson code; MSB is the first stage (A); for WIDTH=4 the bus is {A,B,C,E}.
- clr_err  in  1  synchronous clear of err_count.
- out_valid  out  1  count_out/one_hot were updated from a legal sample this cycle.
- count_out  out  $clog2(N)  decoded count.
- one_hot  out  N  one_hot[count_out] = 1.
- locked  out  1  the FSM is in LOCKED.
- illegal_code  out  1  one-cycle pulse: the sampled code was not a Johnson code.
- seq_error  out  1  one-cycle pulse: an out-of-order legal code arrived while LOCKED.
- err_count  out  ERR_CNT_W  saturating count of illegal_code plus seq_error events.

## Operation
- Legal codes, counted from the MSB:
  - 1^k 0^(WIDTH-k) for k = 0..WIDTH decodes to count k.
  - 0^k 1^(WIDTH-k) for k = 1..WIDTH-1 decodes to count WIDTH+k.
  - For WIDTH=4: 0000→0, 1000→1, 1100→2, 1110→3, 1111→4, 0111→5, 0011→6, 0001→7.
  - Every other code is illegal.
- Successor: (prev+1) mod N; 7→0 is a legal step.
- Hold: the same count as prev; legal in every state, with no error and no progress.
- Samples with in_valid=0 are ignored; no state or output changes except the pulses returning to 0.
- FSM states are IDLE, ACQUIRE and LOCKED; prev count and good_cnt are internal.
  - IDLE:
    - legal code → ACQUIRE, prev=code, good_cnt=0.
    - illegal code → stay in IDLE, pulse illegal_code.
  - ACQUIRE:
    - successor → good_cnt+1; reaching LOCK_CNT → LOCKED.
    - hold → no change.
    - other legal code → prev=code, good_cnt=0, no error flagged.
    - illegal code → IDLE, pulse illegal_code.
  - LOCKED:
    - successor or hold → stay.
    - other legal code → pulse seq_error, go to ACQUIRE, prev=code, good_cnt=0.
    - illegal code → IDLE, pulse illegal_code.
- Outputs:
  - On a legal sample: count_out/one_hot update and out_valid=1.
  - On an illegal sample: out_valid=0 and count_out/one_hot hold their last legal value.
- err_count:
  - Increments by 1 per illegal_code or seq_error pulse; the two never pulse in the same cycle.
  - Saturates at 2^ERR_CNT_W-1.
  - clr_err forces 0 and wins over a same-cycle increment.

## Timing
- All outputs are registered, with latency 1: a code sampled at edge t is reflected after edge t.
- locked rises in the cycle after the sample that completes the LOCK_CNT-th successor step.
- locked falls in the cycle after the offending sample.
- Reset (rstn=0 at an edge) values:
  - state IDLE, prev=0, good_cnt=0.
  - count_out=0, one_hot=0, out_valid=0, locked=0, illegal_code=0, seq_error=0, err_count=0.
  - Reset takes priority over in_valid and clr_err.
- Reset asserted mid-sequence discards lock; reacquisition starts from the first legal sample after rstn=1.
- Pulses last exactly one cycle per offending sample; back-to-back illegal samples give back-to-back pulses.

## Test plan
- Lock-in: after reset, in_valid=1 with 0000, 1000, 1100 on consecutive edges (LOCK_CNT=2) → count_out 0, 1, 2 one cycle later each, one_hot 01h/02h/04h, locked=1 the cycle after 1100, no errors.
- Wrap: locked, feed 1110, 1111, 0111, 0011, 0001, 0000, 1000 → count_out 3, 4, 5, 6, 7, 0, 1; seq_error never asserts; err_count stays 0.
- Illegal code: locked at count 2, feed 1010 → illegal_code one cycle, out_valid=0, count_out holds 2, locked=0, err_count=1; next legal 1110 → ACQUIRE, count_out=3.
- Sequence error and holds:
  - Locked at 0111 (5), feed 0000 → seq_error one cycle, err_count+1, locked=0, count_out=0; 1000, 1100 → relock.
  - Repeated 1100 ×3 while locked → no pulses.
  - in_valid=0 gaps → no changes.
- Counter limits: ERR_CNT_W=2, inject 5 illegal codes → err_count 1, 2, 3, 3, 3; clr_err together with a 6th illegal code → illegal_code pulses, err_count=0.
- Reset mid-run: locked at count 4, rstn=0 for one edge → all outputs 0 next cycle; with rstn=1, 0011, 0001, 0000 → count_out 6, 7, 0, relock after the third.
